// File: rtl/issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl
//  Purpose  : Holds one fetched instruction, presents it to the external
//             combinational decoder, checks back-end capacity and issues the
//             decoded result to the ROB plus either the reservation station
//             or the load/store buffer. Illegal words are dropped and counted.
//  Ports    : clk_in/rst_n          clock, asynchronous active-low reset
//             rdy_in/flush_in       global enable, mispredict flush
//             if_*                  instruction-queue handshake and payload
//             dec_*                 latched word out / decoded fields back in
//             rob_full/rs_full/lsb_full/rob_tail  back-end capacity and tag
//             rob_issue/rs_issue/lsb_issue, iss_*  issue strobes and payload
//             ren_en/ren_rd         register-rename request
//             ill_cnt               saturating count of dropped illegal words
//  Revision : 1.0  initial release
// ============================================================================
module issue_ctrl #(
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6,
    parameter int EREG_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_valid,
    input  logic [31:0]       if_code,
    input  logic [31:0]       if_pc,
    input  logic              if_pred,
    output logic              if_ready,
    output logic [31:0]       dec_code,
    output logic [31:0]       dec_pc,
    input  logic [TYPE_W-1:0] dec_type,
    input  logic [EREG_W-1:0] dec_rd,
    input  logic [EREG_W-1:0] dec_rs1,
    input  logic [EREG_W-1:0] dec_rs2,
    input  logic [31:0]       dec_imm,
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    input  logic [ROB_W-1:0]  rob_tail,
    output logic              rob_issue,
    output logic              rs_issue,
    output logic              lsb_issue,
    output logic [TYPE_W-1:0] iss_type,
    output logic [EREG_W-1:0] iss_rd,
    output logic [EREG_W-1:0] iss_rs1,
    output logic [EREG_W-1:0] iss_rs2,
    output logic [31:0]       iss_imm,
    output logic [31:0]       iss_pc,
    output logic              iss_pred,
    output logic [ROB_W-1:0]  iss_tag,
    output logic              ren_en,
    output logic [4:0]        ren_rd,
    output logic [15:0]       ill_cnt
);

    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [15:0] ILL_MAX   = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        pred_q, pred_d;
    logic [15:0] ill_cnt_q, ill_cnt_d;

    logic [6:0]  w_opcode;
    logic        w_hold;
    logic        w_go;
    logic        w_is_lsb;
    logic        w_illegal;
    logic        w_room;
    logic        w_can_issue;
    logic        w_issue;
    logic        w_drop;

    assign w_opcode  = code_q[6:0];
    assign w_hold    = (state_q == HOLD);
    // Flush outranks everything, so it blocks progress just like rdy_in low.
    assign w_go      = rdy_in && !flush_in;
    assign w_is_lsb  = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);
    assign w_illegal = (dec_type == '0);
    assign w_room    = !rob_full && !(w_is_lsb ? lsb_full : rs_full);

    assign w_can_issue = w_hold && w_go && w_room;
    assign w_issue     = w_can_issue && !w_illegal;
    // Illegal words are consumed regardless of back-end capacity.
    assign w_drop      = w_hold && w_go && w_illegal;

    // rst_n gating keeps the handshake quiet for the whole reset window,
    // since IDLE on its own would otherwise advertise readiness.
    assign if_ready = rst_n && w_go && (!w_hold || w_issue || w_drop);

    assign rob_issue = w_issue;
    assign rs_issue  = w_issue && !w_is_lsb;
    assign lsb_issue = w_issue && w_is_lsb;

    assign dec_code = code_q;
    assign dec_pc   = pc_q;

    assign iss_type = dec_type;
    assign iss_rd   = dec_rd;
    assign iss_rs1  = dec_rs1;
    assign iss_rs2  = dec_rs2;
    assign iss_imm  = dec_imm;
    assign iss_pc   = pc_q;
    assign iss_pred = pred_q;
    assign iss_tag  = rob_tail;

    // Stores and branches write no register; x0 is never renamed.
    assign ren_en = w_issue && (w_opcode != OP_BRANCH) && (w_opcode != OP_STORE)
                    && (code_q[11:7] != 5'd0);
    assign ren_rd = code_q[11:7];

    assign ill_cnt = ill_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= 32'd0;
            pc_q      <= 32'd0;
            pred_q    <= 1'b0;
            ill_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            pred_q    <= pred_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pc_d      = pc_q;
        pred_d    = pred_q;
        ill_cnt_d = ill_cnt_q;

        if (flush_in) begin
            state_d = IDLE;
            code_d  = 32'd0;
            pc_d    = 32'd0;
            pred_d  = 1'b0;
        end else if (rdy_in) begin
            if (if_valid && if_ready) begin
                // Accept overlaps the drain of the previous word, giving
                // one instruction per cycle when nothing stalls.
                state_d = HOLD;
                code_d  = if_code;
                pc_d    = if_pc;
                pred_d  = if_pred;
            end else if (w_issue || w_drop) begin
                state_d = IDLE;
            end

            if (w_drop && (ill_cnt_q != ILL_MAX)) begin
                ill_cnt_d = ill_cnt_q + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_issue_ctrl
//  Purpose  : Self-checking bench for issue_ctrl. A small decoder model feeds
//             the DUT's dec_* inputs; an occupancy-queue model of the issue
//             rules is compared against the DUT every cycle, and directed
//             scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_ctrl;

    localparam int ROB_W  = 4;
    localparam int TYPE_W = 6;
    localparam int EREG_W = 6;

    logic              clk_in   = 1'b0;
    logic              rst_n    = 1'b0;
    logic              rdy_in   = 1'b0;
    logic              flush_in = 1'b0;
    logic              if_valid = 1'b0;
    logic [31:0]       if_code  = 32'd0;
    logic [31:0]       if_pc    = 32'd0;
    logic              if_pred  = 1'b0;
    logic              if_ready;
    logic [31:0]       dec_code, dec_pc;
    logic [TYPE_W-1:0] dec_type;
    logic [EREG_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [31:0]       dec_imm;
    logic              rob_full = 1'b0;
    logic              rs_full  = 1'b0;
    logic              lsb_full = 1'b0;
    logic [ROB_W-1:0]  rob_tail = '0;
    logic              rob_issue, rs_issue, lsb_issue;
    logic [TYPE_W-1:0] iss_type;
    logic [EREG_W-1:0] iss_rd, iss_rs1, iss_rs2;
    logic [31:0]       iss_imm, iss_pc;
    logic              iss_pred;
    logic [ROB_W-1:0]  iss_tag;
    logic              ren_en;
    logic [4:0]        ren_rd;
    logic [15:0]       ill_cnt;

    issue_ctrl #(.ROB_W(ROB_W), .TYPE_W(TYPE_W), .EREG_W(EREG_W)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid(if_valid), .if_code(if_code), .if_pc(if_pc), .if_pred(if_pred),
        .if_ready(if_ready), .dec_code(dec_code), .dec_pc(dec_pc),
        .dec_type(dec_type), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail), .rob_issue(rob_issue), .rs_issue(rs_issue),
        .lsb_issue(lsb_issue), .iss_type(iss_type), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_pred(iss_pred), .iss_tag(iss_tag), .ren_en(ren_en), .ren_rd(ren_rd),
        .ill_cnt(ill_cnt)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- decoder model ----------------
    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [EREG_W-1:0] rd;
        logic [EREG_W-1:0] rs1;
        logic [EREG_W-1:0] rs2;
        logic [31:0]       imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] c);
        dec_t d;
        d.typ = '0;
        d.rd  = {1'b0, c[11:7]};
        d.rs1 = {1'b0, c[19:15]};
        d.rs2 = {1'b0, c[24:20]};
        d.imm = 32'd0;
        case (c[6:0])
            7'h13: begin d.typ = 6'd1; d.imm = {{20{c[31]}}, c[31:20]}; end
            7'h03: begin d.typ = 6'd2; d.imm = {{20{c[31]}}, c[31:20]}; end
            7'h23: begin d.typ = 6'd3; d.rd = 6'd32;
                         d.imm = {{20{c[31]}}, c[31:25], c[11:7]}; end
            7'h63: begin d.typ = 6'd4; d.rd = 6'd32; end
            7'h33: begin d.typ = 6'd5; end
            default: begin d.typ = '0; d.rd = 6'd32; end
        endcase
        return d;
    endfunction

    dec_t dd;
    always_comb begin
        dd       = decode(dec_code);
        dec_type = dd.typ;
        dec_rd   = dd.rd;
        dec_rs1  = dd.rs1;
        dec_rs2  = dd.rs2;
        dec_imm  = dd.imm;
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_rs    = 0;
    int n_lsb   = 0;
    int cyc     = 0;
    logic [31:0] log_pc[$];
    int          log_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        held[$];
    logic [31:0] shown_code = 32'd0;
    logic [31:0] shown_pc   = 32'd0;
    logic        shown_pred = 1'b0;
    int          m_ill      = 0;

    initial begin
        logic [31:0] mc;
        logic [6:0]  op;
        dec_t        md;
        bit full, legal, lsbc, room, go, e_iss, e_drop, e_rdy, e_ren, acc;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (!rst_n) begin
                held.delete();
                shown_code = 32'd0;
                shown_pc   = 32'd0;
                shown_pred = 1'b0;
                m_ill      = 0;
                chk("rst_rob_issue", 32'(rob_issue), 32'd0);
                chk("rst_rs_issue",  32'(rs_issue),  32'd0);
                chk("rst_lsb_issue", 32'(lsb_issue), 32'd0);
                chk("rst_if_ready",  32'(if_ready),  32'd0);
                chk("rst_ren_en",    32'(ren_en),    32'd0);
                chk("rst_ill_cnt",   32'(ill_cnt),   32'd0);
                chk("rst_dec_code",  dec_code,       32'd0);
                continue;
            end
            full   = (held.size() != 0);
            mc     = full ? held[0].code : shown_code;
            op     = mc[6:0];
            md     = decode(mc);
            lsbc   = (op == 7'h03) || (op == 7'h23);
            legal  = (md.typ != 0);
            room   = !rob_full && !(lsbc ? lsb_full : rs_full);
            go     = rdy_in && !flush_in;
            e_iss  = full && go && legal && room;
            e_drop = full && go && !legal;
            e_rdy  = go && (!full || e_iss || e_drop);
            e_ren  = e_iss && (op != 7'h63) && (op != 7'h23) && (mc[11:7] != 5'd0);
            acc    = if_valid && e_rdy;

            chk("rob_issue", 32'(rob_issue), 32'(e_iss));
            chk("rs_issue",  32'(rs_issue),  32'(e_iss && !lsbc));
            chk("lsb_issue", 32'(lsb_issue), 32'(e_iss && lsbc));
            chk("if_ready",  32'(if_ready),  32'(e_rdy));
            chk("ren_en",    32'(ren_en),    32'(e_ren));
            chk("dec_code",  dec_code,       mc);
            chk("dec_pc",    dec_pc,         full ? held[0].pc : shown_pc);
            chk("ill_cnt",   32'(ill_cnt),   32'(m_ill));
            if (e_iss) begin
                chk("iss_type", 32'(iss_type), 32'(md.typ));
                chk("iss_rd",   32'(iss_rd),   32'(md.rd));
                chk("iss_rs1",  32'(iss_rs1),  32'(md.rs1));
                chk("iss_rs2",  32'(iss_rs2),  32'(md.rs2));
                chk("iss_imm",  iss_imm,       md.imm);
                chk("iss_pc",   iss_pc,        held[0].pc);
                chk("iss_pred", 32'(iss_pred), 32'(held[0].pred));
                chk("iss_tag",  32'(iss_tag),  32'(rob_tail));
            end
            if (e_ren) chk("ren_rd", 32'(ren_rd), 32'(mc[11:7]));

            if (rob_issue) begin
                log_pc.push_back(iss_pc);
                log_cyc.push_back(cyc);
            end
            if (rs_issue)  n_rs++;
            if (lsb_issue) n_lsb++;

            @(posedge clk_in);
            if (rst_n) begin
                if (flush_in) begin
                    held.delete();
                    shown_code = 32'd0;
                    shown_pc   = 32'd0;
                    shown_pred = 1'b0;
                end else if (rdy_in) begin
                    if (e_iss || e_drop) void'(held.pop_front());
                    if (e_drop && m_ill < 65535) m_ill++;
                    if (acc) begin
                        held.push_back('{if_code, if_pc, if_pred});
                        shown_code = if_code;
                        shown_pc   = if_pc;
                        shown_pred = if_pred;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] pc, input logic pred);
        bit got;
        got      = 0;
        if_valid = 1'b1;
        if_code  = c;
        if_pc    = pc;
        if_pred  = pred;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (if_ready) begin
                got = 1;
                break;
            end
        end
        chk("push_accept", 32'(got), 32'd1);
        @(posedge clk_in);
        #1;
        if_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        // 1: reset, then addi x1,x0,5
        rdy_in   = 1'b1;
        rob_tail = 4'd3;
        @(negedge clk_in);
        chk("t1_rst_if_ready", 32'(if_ready), 32'd0);
        chk("t1_rst_ill_cnt",  32'(ill_cnt),  32'd0);
        step(1);
        rst_n = 1'b1;
        push(32'h00500093, 32'h0, 1'b1);
        @(negedge clk_in);
        chk("t1_rs_issue",  32'(rs_issue),  32'd1);
        chk("t1_rob_issue", 32'(rob_issue), 32'd1);
        chk("t1_lsb_issue", 32'(lsb_issue), 32'd0);
        chk("t1_iss_imm",   iss_imm,        32'd5);
        chk("t1_ren_en",    32'(ren_en),    32'd1);
        chk("t1_ren_rd",    32'(ren_rd),    32'd1);
        chk("t1_iss_tag",   32'(iss_tag),   32'd3);
        chk("t1_iss_pred",  32'(iss_pred),  32'd1);
        step(1);

        // 2: sw x2,8(x1) stalled by lsb_full for 3 cycles
        lsb_full = 1'b1;
        rob_tail = 4'd9;
        push(32'h0020A423, 32'h4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("t2_stall_lsb",   32'(lsb_issue), 32'd0);
            chk("t2_stall_rob",   32'(rob_issue), 32'd0);
            chk("t2_stall_ready", 32'(if_ready),  32'd0);
            step(1);
        end
        lsb_full = 1'b0;
        base     = n_lsb;
        @(negedge clk_in);
        chk("t2_lsb_issue", 32'(lsb_issue), 32'd1);
        chk("t2_rs_issue",  32'(rs_issue),  32'd0);
        chk("t2_ren_en",    32'(ren_en),    32'd0);
        chk("t2_iss_imm",   iss_imm,        32'd8);
        chk("t2_iss_rs1",   32'(iss_rs1),   32'd1);
        chk("t2_iss_rs2",   32'(iss_rs2),   32'd2);
        chk("t2_iss_tag",   32'(iss_tag),   32'd9);
        step(3);
        chk("t2_lsb_pulses", 32'(n_lsb - base), 32'd1);

        // 3: back-to-back stream of four addi words
        base = log_pc.size();
        for (int k = 0; k < 4; k++) begin
            if_valid = 1'b1;
            if_code  = 32'h00500013 | (32'(k + 1) << 7);
            if_pc    = 32'(k * 4);
            if_pred  = 1'b0;
            rob_tail = 4'(k);
            @(negedge clk_in);
            chk("t3_if_ready", 32'(if_ready), 32'd1);
            step(1);
        end
        if_valid = 1'b0;
        step(3);
        chk("t3_issue_count", 32'(log_pc.size() - base), 32'd4);
        if (log_pc.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) chk("t3_pc_order", log_pc[base + k], 32'(k * 4));
            for (int k = 0; k < 3; k++)
                chk("t3_back_to_back", 32'(log_cyc[base + k + 1] - log_cyc[base + k]), 32'd1);
        end

        // 4: held by rob_full, then flushed
        rob_full = 1'b1;
        push(32'h00700113, 32'h100, 1'b0);
        step(2);
        flush_in = 1'b1;
        @(negedge clk_in);
        chk("t4_flush_rob",   32'(rob_issue), 32'd0);
        chk("t4_flush_ready", 32'(if_ready),  32'd0);
        step(1);
        flush_in = 1'b0;
        rob_full = 1'b0;
        base     = log_pc.size();
        step(3);
        chk("t4_never_issued", 32'(log_pc.size() - base), 32'd0);
        chk("t4_latch_clear",  dec_code, 32'd0);

        // 5: illegal drop and counter saturation
        push(32'h00000000, 32'h200, 1'b0);
        @(negedge clk_in);
        chk("t5_drop_rob",   32'(rob_issue), 32'd0);
        chk("t5_drop_ready", 32'(if_ready),  32'd1);
        step(1);
        chk("t5_ill_one", 32'(ill_cnt), 32'd1);
        if_valid = 1'b1;
        if_code  = 32'h00000000;
        if_pc    = 32'h204;
        step(65534);
        if_valid = 1'b0;
        step(2);
        chk("t5_ill_max", 32'(ill_cnt), 32'h0000FFFF);
        push(32'h00000000, 32'h208, 1'b0);
        step(2);
        chk("t5_ill_sat", 32'(ill_cnt), 32'h0000FFFF);

        // 6: rdy_in low while holding, then reset mid-hold
        push(32'h00300193, 32'h300, 1'b1);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            chk("t6_frozen_rob", 32'(rob_issue), 32'd0);
            chk("t6_frozen_pc",  dec_pc,         32'h300);
            step(1);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk("t6_resume_rob", 32'(rob_issue), 32'd1);
        chk("t6_resume_pc",  iss_pc,         32'h300);
        step(1);
        push(32'h00400213, 32'h400, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rob",   32'(rob_issue), 32'd0);
        chk("t6_rst_rs",    32'(rs_issue),  32'd0);
        chk("t6_rst_ready", 32'(if_ready),  32'd0);
        chk("t6_rst_code",  dec_code,       32'd0);
        base = log_pc.size();
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("t6_discarded", 32'(log_pc.size() - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sequences the combinational instruction decoder between the instruction queue and the out-of-order back end.
- Latches one fetched instruction and presents it to the decoder.
- Checks ROB and reservation-station / load-store-buffer capacity, then issues the decoded instruction with its ROB tag and register-rename request.
- Handles flush, pause and illegal-instruction drop.

Parameters:
ROB_W, 4, ROB index width
TYPE_W, 6, decoded instruction-type width (0 = empty/illegal)
EREG_W, 6, extended register index width; value 32 = "no register"

Ports:
clk_in  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low = freeze
flush_in  in  1  mispredict flush from ROB, synchronous
if_valid  in  1  instruction-queue entry valid
if_code  in  32  instruction word
if_pc  in  32  instruction PC
if_pred  in  1  predicted-taken bit
if_ready  out  1  controller accepts this cycle (combinational)
dec_code  out  32  latched word to decoder
dec_pc  out  32  latched PC to decoder
dec_type  in  TYPE_W  decoder type
dec_rd, dec_rs1, dec_rs2  in  EREG_W  decoder register fields
dec_imm  in  32  decoder immediate
rob_full, rs_full, lsb_full  in  1  consumer has no free entry
rob_tail  in  ROB_W  ROB index the next entry will take
rob_issue, rs_issue, lsb_issue  out  1  issue strobes
iss_type  out  TYPE_W  issued type
iss_rd, iss_rs1, iss_rs2  out  EREG_W  issued register fields
iss_imm, iss_pc  out  32  issued immediate and PC
iss_pred  out  1  issued prediction bit
iss_tag  out  ROB_W  = rob_tail
ren_en  out  1  rename rd to iss_tag
ren_rd  out  5  register to rename
ill_cnt  out  16  dropped illegal instructions, saturating

Behaviour:
- States: IDLE (latch empty), HOLD (latch full).
- Reset (asynchronous): state IDLE, latch code/pc/pred = 0, ill_cnt = 0.
  - All strobes, if_ready and ren_en read 0 while rst_n is low.
- dec_code/dec_pc are driven directly from the latch.
- iss_* outputs are combinational from the decoder inputs and latch; they are don't-care unless a strobe is high.
- Class is taken from latched code[6:0]:
  - 0x03 or 0x23 → LSB.
  - Any other opcode with dec_type != 0 → RS.
  - dec_type == 0 → illegal.
- can_issue = state==HOLD && rdy_in && !flush_in && !rob_full && !(RS ? rs_full : lsb_full).
- Illegal in HOLD (rdy_in high, no flush): the instruction is consumed at the edge with no strobes, and ill_cnt increments, saturating at 0xFFFF.
- Issue cycle (can_issue high, legal instruction):
  - rob_issue = 1 together with exactly one of rs_issue or lsb_issue.
  - iss_tag = rob_tail.
  - ren_en = 1 only when opcode is neither 0x63 nor 0x23 and rd != 0; ren_rd = code[11:7].
- if_ready = rdy_in && !flush_in && (state==IDLE || can_issue || HOLD-illegal).
- Transitions at the rising edge:
  - if_valid && if_ready → latch the new word, state HOLD. This gives back-to-back throughput of 1 per cycle.
  - HOLD drained (issued or dropped) with no new accept → IDLE.
  - HOLD not drained → remain in HOLD, latch unchanged.
- Latency: a word accepted at edge N issues during cycle N+1 at the earliest.
- Strobes are high for exactly one cycle per instruction; no duplicate issue while stalled.
- flush_in has priority over all other events:
  - No strobes and if_ready = 0 in the flush cycle.
  - Latch cleared; next state IDLE.
  - ill_cnt is kept.
- rdy_in low: no strobes, no capture, state and latch held.
  - flush_in with rdy_in low is still honoured.
- rst_n asserted mid-stall discards the held instruction immediately.

Test Plan:
1. Reset, then if_valid with addi x1,x0,5 (0x00500093, pc 0x0): one cycle later rs_issue = rob_issue = 1, iss_imm = 5, ren_en = 1, ren_rd = 1, iss_tag = rob_tail.
2. sw x2,8(x1) (0x0020A423) with lsb_full = 1 for 3 cycles: no strobes and if_ready = 0 during the stall; lsb_issue is a single pulse after release; ren_en = 0.
3. Stream of 4 valid words, no full flags: one issue per cycle, consecutive PCs 0,4,8,12; if_ready stays high.
4. HOLD with rob_full = 1, then flush_in pulse: no strobe that cycle, state IDLE, the held instruction is never issued.
5. Word 0x00000000 (dec_type 0): no strobes, ill_cnt becomes 1; pre-load ill_cnt to 0xFFFF and repeat → ill_cnt stays 0xFFFF.
6. rdy_in low for 2 cycles while HOLD with resources free: no strobes; issue occurs in the first cycle rdy_in returns high. rst_n pulsed mid-HOLD: strobes 0 at once, IDLE afterwards.
